// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_pkg
//  Description : Shared FSM state encoding and default operand width for the
//                bit-serial add/subtract controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    // Operand/result width used when the instantiating parent does not override it
    localparam int DEFAULT_WIDTH = 32;

    // Controller states: accept in IDLE, one bit per cycle in RUN, hold result in DONE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_fa_bit.sv
`default_nettype none
// ============================================================================
//  Module      : FA_Bit
//  Description : Single-bit full adder cell used as the serial datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module FA_Bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and majority carry of the three input bits
    always_comb begin
        s    = x ^ y ^ cin;
        cout = (x & y) | (x & cin) | (y & cin);
    end

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial add/subtract controller. An accepted operation is
//                processed LSB first, one full-adder cell per cycle, and the
//                result with carry/overflow/zero flags is held until taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   count;
    logic               accept;
    logic               last_bit;
    logic               fa_s;
    logic               fa_cout;
    logic [WIDTH-1:0]   result_shifted;

    assign accept         = start_valid & start_ready;
    assign last_bit       = (count == LAST_CNT);
    // Result register after this cycle's sum bit enters from the MSB side
    assign result_shifted = {fa_s, result[WIDTH-1:1]};
    // The carry flop holds the MSB carry-out once RUN has completed
    assign carry_out      = carry;

    FA_Bit u_fa_bit (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; start_ready is gated so it stays low during reset
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                start_ready = rst_n;
                if (start_valid && rst_n) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Serial datapath: load on accept, one bit per RUN cycle, flags captured on the MSB cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            count    <= '0;
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_sh  <= op_a;
            // Subtraction as A + ~B + 1: invert B and seed the carry with 1
            b_sh  <= sub ? ~op_b : op_b;
            carry <= sub;
            count <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= fa_cout;
            count  <= count + CNT_W'(1);
            result <= result_shifted;
            if (last_bit) begin
                // carry still holds the carry into the MSB stage at this point
                overflow <= carry ^ fa_cout;
                zero     <= ~|result_shifted;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 32; operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start_valid  input  1  requester presents an operation.
REQ-005 start_ready  output  1  controller can accept an operation.
REQ-006 op_a  input  WIDTH  first operand, sampled on accept.
REQ-007 op_b  input  WIDTH  second operand, sampled on accept.
REQ-008 sub  input  1  0 = A+B, 1 = A-B; sampled on accept.
REQ-009 res_valid  output  1  result fields valid.
REQ-010 res_ready  input  1  consumer takes the result.
REQ-011 result  output  WIDTH  sum or difference.
REQ-012 carry_out  output  1  carry out of the MSB stage; for subtract, 1 means no borrow.
REQ-013 overflow  output  1  two's-complement overflow.
REQ-014 zero  output  1  result equals 0.
REQ-015 busy  output  1  high in RUN.

Function
REQ-016 The block SHALL compute the result bit-serially, LSB first, using one full-adder bit cell per cycle and a registered carry.
REQ-017 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 start_ready SHALL be 1 only in IDLE; accept = start_valid & start_ready.
REQ-019 On accept, the block SHALL:
  - load A into a shift register;
  - load B into a shift register, bitwise inverted when sub=1;
  - load the carry flop with sub;
  - clear the bit counter;
  - enter RUN.
REQ-020 In RUN, each cycle SHALL:
  - add the LSBs of A and B with the carry flop;
  - shift the sum bit into the result register from the MSB side;
  - shift A and B right;
  - update the carry flop;
  - increment the counter.
REQ-021 The counter SHALL be $clog2(WIDTH) bits wide; RUN SHALL last exactly WIDTH cycles, leaving RUN on the cycle with count = WIDTH-1.
REQ-022 On the MSB cycle, the block SHALL capture carry-in to the MSB stage; overflow SHALL equal that carry-in XOR carry_out.
REQ-023 Timing: if accept occurs at edge N, res_valid SHALL rise after edge N+WIDTH (latency WIDTH+1 cycles from accept to result).
REQ-024 In DONE, res_valid SHALL be 1, and result, carry_out, overflow and zero SHALL be held stable until res_ready=1.
REQ-025 In DONE with res_ready=1, the block SHALL return to IDLE on the next edge; start_valid is ignored in DONE; throughput is one operation per WIDTH+2 cycles.
REQ-026 zero SHALL be the registered NOR of result, valid whenever res_valid=1.
REQ-027 Changes to op_a, op_b or sub after accept SHALL NOT affect the operation in flight.
REQ-028 In IDLE and RUN, res_valid SHALL be 0; result and flag values outside res_valid=1 are don't-care to consumers.

Reset
REQ-029 On rst_n=0, the block SHALL, at any time including mid-RUN or in DONE, asynchronously:
  - force IDLE;
  - clear the counter, carry flop, shift registers, result and flags;
  - drive start_ready=0, res_valid=0, busy=0 while rst_n=0.
REQ-030 The first accept after reset SHALL be possible on the first rising edge with rst_n=1; any in-flight operation is discarded with no result produced.

Structure
REQ-031 Package serial_add_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-032 Exactly one sub-module SHALL be instantiated: FA_Bit (x, y, cin -> s, cout); all other logic is inline.

Verification (WIDTH=32)
REQ-033 A=5, B=3, sub=0 -> result=8, carry_out=0, overflow=0, zero=0; res_valid rises exactly 33 cycles after accept.
REQ-034 A=0xFFFFFFFF, B=1, sub=0 -> result=0, carry_out=1, zero=1, overflow=0.
REQ-035 A=0x7FFFFFFF, B=1, sub=0 -> result=0x80000000, overflow=1, carry_out=0; A=5, B=7, sub=1 -> result=0xFFFFFFFE, carry_out=0, overflow=0.
REQ-036 res_ready held 0 for 10 cycles in DONE -> outputs stable, start_ready=0, new start_valid ignored; res_ready=1 -> IDLE next cycle, start_ready=1.
REQ-037 rst_n pulsed low at RUN count 15 -> res_valid never asserts for that operation; a following accept of 2+2 yields 4 after 33 cycles.
